// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg
// Shared constants and the sequencer state type for tensor_core_driver and
// its result serializer.
//   ELEM_W / DIM / MATRIX_W : 4x4 matrix of 4-bit elements packed into 64 bits
//   LOAD_BYTES / RESULT_BYTES : bytes per operand load / per result unload
//   driver_state_t : sequencer state, also exposed on the driver's debug port
package tensor_core_pkg;

    localparam int ELEM_W       = 4;
    localparam int DIM          = 4;
    localparam int MATRIX_W     = 64;
    localparam int LOAD_BYTES   = 16;
    localparam int RESULT_BYTES = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } driver_state_t;

endpackage

// File: rtl/tensor_core_driver_if.sv
// tensor_core_driver_if
// Host-facing byte streams and status of tensor_core_driver.
//   load_*   : operand byte stream into the driver
//   result_* : result byte stream out of the driver
//   busy_out, error_out : driver status
// Modports: master = host/fabric side, slave = tensor_core_driver.
//
// Handshake (both streams): a byte moves on a rising edge where valid and
// ready are both high. The producer holds valid and data stable until that
// edge; valid never depends combinationally on ready.
interface tensor_core_driver_if;

    logic [7:0] load_data_in;
    logic       load_valid_in;
    logic       load_ready_out;
    logic [7:0] result_data_out;
    logic       result_valid_out;
    logic       result_ready_in;
    logic       busy_out;
    logic       error_out;

    modport master (
        output load_data_in, load_valid_in, result_ready_in,
        input  load_ready_out, result_data_out, result_valid_out, busy_out, error_out
    );

    modport slave (
        input  load_data_in, load_valid_in, result_ready_in,
        output load_ready_out, result_data_out, result_valid_out, busy_out, error_out
    );

endinterface

// File: rtl/tensor_result_serializer.sv
// tensor_result_serializer
// Holds the captured 64-bit product and streams it out MSB byte first.
// Ports:
//   clock_in, reset_n_in : clock, async active-low reset
//   capture, capture_data: load a new product and start streaming
//   data, valid, ready   : result byte stream
//   last_accepted        : high in the cycle the final byte is handed over
module tensor_result_serializer
    import tensor_core_pkg::*;
(
    input  logic                clock_in,
    input  logic                reset_n_in,
    input  logic                capture,
    input  logic [MATRIX_W-1:0] capture_data,
    output logic [7:0]          data,
    output logic                valid,
    input  logic                ready,
    output logic                last_accepted
);

    logic [MATRIX_W-1:0] result_q;
    logic [2:0]          byte_cnt;
    logic                valid_q;
    logic                fire;

    assign fire          = valid_q && ready;
    assign last_accepted = fire && (byte_cnt == 3'(RESULT_BYTES - 1));

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            result_q <= '0;
            byte_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (capture) begin
            result_q <= capture_data;
            byte_cnt <= '0;
            valid_q  <= 1'b1;
        end else if (fire) begin
            byte_cnt <= byte_cnt + 3'd1;
            if (last_accepted) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Byte 0 is bits 63:56; the counter walks down towards bits 7:0.
    assign data  = result_q[8 * (RESULT_BYTES - 1 - int'(byte_cnt)) +: 8];
    assign valid = valid_q;

endmodule

// File: rtl/tensor_core_driver.sv
// tensor_core_driver
// Loads two 4x4 signed 4-bit matrices from a byte stream, starts
// small_tensor_core, waits for completion and streams the product back.
// Ports:
//   clock_in, reset_n_in  : clock, async active-low reset
//   bus (slave)           : load/result byte streams, busy_out, error_out
//   tensor_core_*         : operand buses, write enable, product bus
//   is_done_with_calculation : core completion flag
//   state_out             : current sequencer state (debug)
// Optional feature: define TENSOR_CORE_DRIVER_TIMEOUT_EN to bound the WAIT
// state by TIMEOUT_CYCLES and report expiry on error_out.
module tensor_core_driver
    import tensor_core_pkg::*;
#(
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    tensor_core_driver_if.slave  bus,
    output logic                 tensor_core_register_file_write_enable,
    output logic [MATRIX_W-1:0]  tensor_core_input1,
    output logic [MATRIX_W-1:0]  tensor_core_input2,
    input  logic [MATRIX_W-1:0]  tensor_core_output,
    input  logic                 is_done_with_calculation,
    output driver_state_t        state_out
);

    localparam int START_W = $clog2(START_CYCLES + 1);

    driver_state_t       state, state_next;
    logic [3:0]          load_cnt;
    logic [START_W-1:0]  start_cnt;
    logic                wait_armed;
    logic [MATRIX_W-1:0] input1_q, input2_q;
    logic                load_ready;
    logic                load_fire;
    logic                write_enable;
    logic                capture;
    logic                last_accepted;
    logic                timeout_hit;
    logic                start_last;

    assign load_fire  = bus.load_valid_in && load_ready;
    assign start_last = (start_cnt == START_W'(START_CYCLES - 1));
    // The first WAIT cycle may still show the previous run's done flag.
    assign capture    = (state == ST_WAIT) && wait_armed && is_done_with_calculation;

`ifdef TENSOR_CORE_DRIVER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            error_q;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Done wins over the watchdog when both land in the same cycle.
    assign timeout_hit = (state == ST_WAIT) && !capture &&
                         (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end else if (load_fire && (load_cnt == 4'd0)) begin
            error_q <= 1'b0;
        end
    end

    assign bus.error_out = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign bus.error_out  = 1'b0;
`endif

    // State register
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_next   = state;
        load_ready   = 1'b0;
        write_enable = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_fire && (load_cnt == 4'(LOAD_BYTES - 1))) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                write_enable = 1'b1;
                if (start_last) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    state_next = ST_UNLOAD;
                end else if (timeout_hit) begin
                    state_next = ST_LOAD;
                end
            end
            ST_UNLOAD: begin
                if (last_accepted) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Operand assembly: bytes 0-7 go to input1, 8-15 to input2, MSB first.
    // The 4-bit counter wraps to 0 by itself after byte 15.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            load_cnt <= '0;
            input1_q <= '0;
            input2_q <= '0;
        end else if (load_fire) begin
            load_cnt <= load_cnt + 4'd1;
            if (!load_cnt[3]) begin
                input1_q[8 * (7 - int'(load_cnt[2:0])) +: 8] <= bus.load_data_in;
            end else begin
                input2_q[8 * (7 - int'(load_cnt[2:0])) +: 8] <= bus.load_data_in;
            end
        end
    end

    // START duration counter and WAIT first-cycle marker. WAIT is always
    // entered from START, which clears the marker.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            start_cnt  <= '0;
            wait_armed <= 1'b0;
        end else begin
            if (state == ST_START && !start_last) begin
                start_cnt <= start_cnt + START_W'(1);
            end else begin
                start_cnt <= '0;
            end
            wait_armed <= (state == ST_WAIT);
        end
    end

    tensor_result_serializer u_serializer (
        .clock_in      (clock_in),
        .reset_n_in    (reset_n_in),
        .capture       (capture),
        .capture_data  (tensor_core_output),
        .data          (bus.result_data_out),
        .valid         (bus.result_valid_out),
        .ready         (bus.result_ready_in),
        .last_accepted (last_accepted)
    );

    assign bus.load_ready_out                     = load_ready;
    assign bus.busy_out                           = (state != ST_LOAD);
    assign tensor_core_register_file_write_enable = write_enable;
    assign tensor_core_input1                     = input1_q;
    assign tensor_core_input2                     = input2_q;
    assign state_out                              = state;

endmodule

// File: tb/tb_tensor_core_driver.sv
// tb_tensor_core_driver
// Bench for tensor_core_driver with a behavioural small_tensor_core stand-in.
// Expected result bytes come from a matrix-product reference computed on the
// bytes the bench sends. Define TENSOR_CORE_DRIVER_TIMEOUT_EN to also run the
// watchdog scenario (TIMEOUT_CYCLES=16).
module tb_tensor_core_driver;
    import tensor_core_pkg::*;

`ifdef TENSOR_CORE_DRIVER_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 64;
`endif
    localparam int START_CYC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tensor_core_driver_if bus();
    logic          we;
    logic [63:0]   in1, in2;
    logic [63:0]   core_out;
    logic          core_done;
    driver_state_t dbg_state;

    tensor_core_driver #(.START_CYCLES(START_CYC), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clock_in                               (clk),
        .reset_n_in                             (rst_n),
        .bus                                    (bus.slave),
        .tensor_core_register_file_write_enable (we),
        .tensor_core_input1                     (in1),
        .tensor_core_input2                     (in2),
        .tensor_core_output                     (core_out),
        .is_done_with_calculation               (core_done),
        .state_out                              (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int elem(input logic [63:0] m, input int i, input int j);
        logic signed [3:0] e;
        e = m[((DIM - 1 - i) * DIM + (DIM - 1 - j)) * ELEM_W +: ELEM_W];
        return int'(e);
    endfunction

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int acc;
        r = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++) acc += elem(a, i, k) * elem(b, k, j);
                r[((DIM - 1 - i) * DIM + (DIM - 1 - j)) * ELEM_W +: ELEM_W] = acc[3:0];
            end
        end
        return r;
    endfunction

    // ---------------- tensor core stand-in ----------------
    int core_lat = 3;
    bit core_mute = 0;
    bit core_stale = 0;
    int core_cnt;
    bit core_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b0;
            core_out  <= '0;
            core_pend <= 1'b0;
            core_cnt  <= 0;
        end else if (we) begin
            core_pend <= 1'b1;
            core_cnt  <= core_lat;
            if (!core_stale) core_done <= 1'b0;
        end else if (core_pend) begin
            if (core_cnt <= 1 && !core_mute) begin
                core_out  <= ref_mul(in1, in2);
                core_done <= 1'b1;
                core_pend <= 1'b0;
            end else begin
                core_done <= 1'b0;
                if (core_cnt > 1) core_cnt <= core_cnt - 1;
            end
        end
    end

    // ---------------- result ready driver ----------------
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.result_ready_in = 1'b1;
            1:       bus.result_ready_in = 1'($urandom_range(0, 1));
            default: bus.result_ready_in = 1'b0;
        endcase
    end

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]  exp_q[$];
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];
    int          rx_count = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0]  prev_d = '0;
    int          we_len = 0;
    bit          in_run = 0;
    logic [63:0] held_a, held_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            we_len = 0;
            in_run = 0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", 64'(bus.result_valid_out), 64'(1));
                check("hold_data", 64'(bus.result_data_out), 64'(prev_d));
            end
            if (bus.result_valid_out && bus.result_ready_in) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %h expected none", bus.result_data_out);
                end else begin
                    check("result_byte", 64'(bus.result_data_out), 64'(exp_q.pop_front()));
                end
                rx_count++;
            end
            prev_v = bus.result_valid_out;
            prev_r = bus.result_ready_in;
            prev_d = bus.result_data_out;

            if (we) begin
                if (we_len == 0 && exp_a_q.size() != 0) begin
                    held_a = exp_a_q.pop_front();
                    held_b = exp_b_q.pop_front();
                    check("input1_at_start", in1, held_a);
                    check("input2_at_start", in2, held_b);
                    in_run = 1;
                end
                we_len++;
            end else if (we_len != 0) begin
                check("we_width", 64'(we_len), 64'(START_CYC));
                we_len = 0;
            end
            if (in_run && dbg_state == ST_UNLOAD) begin
                check("input1_stable", in1, held_a);
                check("input2_stable", in2, held_b);
                in_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int t;
        bus.load_data_in  = b;
        bus.load_valid_in = 1'b1;
        t = 0;
        while (!bus.load_ready_out && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("load_ready_timeout", 64'(bus.load_ready_out), 64'(1));
        @(posedge clk); #1;
        bus.load_valid_in = 1'b0;
    endtask

    task automatic load_pair(input logic [63:0] a, input logic [63:0] b,
                             input bit toggle, input bit expect_result);
        logic [63:0] r;
        r = ref_mul(a, b);
        if (expect_result) begin
            for (int i = 0; i < RESULT_BYTES; i++) exp_q.push_back(r[8 * (7 - i) +: 8]);
        end
        exp_a_q.push_back(a);
        exp_b_q.push_back(b);
        for (int i = 0; i < LOAD_BYTES; i++) begin
            send_byte(i < 8 ? a[8 * (7 - i) +: 8] : b[8 * (15 - i) +: 8]);
            if (toggle) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || dbg_state != ST_LOAD) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) begin
            check("run_timeout_pending", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    task automatic wait_state(input driver_state_t s);
        int t;
        t = 0;
        while (dbg_state != s && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("wait_state_timeout", 64'(dbg_state), 64'(s));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load_ready"}, 64'(bus.load_ready_out), 64'(1));
        check({tag, "_result_valid"}, 64'(bus.result_valid_out), 64'(0));
        check({tag, "_result_data"}, 64'(bus.result_data_out), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy_out), 64'(0));
        check({tag, "_error"}, 64'(bus.error_out), 64'(0));
        check({tag, "_we"}, 64'(we), 64'(0));
        check({tag, "_input1"}, in1, 64'(0));
        check({tag, "_input2"}, in2, 64'(0));
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_LOAD));
    endtask

    // ---------------- main sequence ----------------
    localparam logic [63:0] ID_A = 64'h1000_0100_0010_0001;
    localparam logic [63:0] ID_B = 64'h1234_5670_1234_5670;

    initial begin
        int base;
        int n;
        logic [63:0] id_exp;
        logic [63:0] ra, rb;

        bus.load_data_in  = '0;
        bus.load_valid_in = 1'b0;
        rst_n = 1'b0;
        #23;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");

        // Identity, back-to-back bytes; expected bytes are B itself.
        id_exp = ID_B;
        check("identity_ref", ref_mul(ID_A, ID_B), id_exp);
        load_pair(ID_A, ID_B, 0, 1);
        wait_done();

        // Identity with load valid toggling every other cycle
        load_pair(ID_A, ID_B, 1, 1);
        wait_done();

        // Result backpressure after byte 3
        base = rx_count;
        load_pair({$urandom, $urandom}, {$urandom, $urandom}, 0, 1);
        n = 0;
        while (rx_count < base + 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1;
        check("stalled_valid", 64'(bus.result_valid_out), 64'(1));
        rdy_mode = 0;
        wait_done();
        check("backpressure_count", 64'(rx_count - base), 64'(RESULT_BYTES));

        // Bytes offered during WAIT must not be consumed
        core_lat = 20;
        load_pair({$urandom, $urandom}, {$urandom, $urandom}, 0, 1);
        wait_state(ST_WAIT);
        bus.load_data_in  = 8'hAA;
        bus.load_valid_in = 1'b1;
        repeat (4) begin
            check("ready_in_wait", 64'(bus.load_ready_out), 64'(0));
            check("busy_in_wait", 64'(bus.busy_out), 64'(1));
            @(posedge clk); #1;
        end
        bus.load_valid_in = 1'b0;
        wait_done();

        // Stale done visible on the first WAIT cycle
        core_stale = 1;
        repeat (3) begin
            core_lat = $urandom_range(1, 4);
            load_pair({$urandom, $urandom}, {$urandom, $urandom}, 0, 1);
            wait_done();
        end
        core_stale = 0;

        // Randomized runs
        rdy_mode = 1;
        repeat (20) begin
            core_lat = $urandom_range(1, 6);
            load_pair({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
            wait_done();
        end
        rdy_mode = 0;

        // Reset while in WAIT
        core_lat = 40;
        load_pair({$urandom, $urandom}, {$urandom, $urandom}, 0, 1);
        wait_state(ST_WAIT);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("wait_reset");
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        core_lat = 2;
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        load_pair(ra, rb, 0, 1);
        wait_done();

`ifdef TENSOR_CORE_DRIVER_TIMEOUT_EN
        // Watchdog: done never arrives
        core_mute = 1;
        load_pair({$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
        wait_state(ST_WAIT);
        n = 0;
        while (dbg_state == ST_WAIT && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_wait_cycles", 64'(n), 64'(TO_CYC));
        check("timeout_error", 64'(bus.error_out), 64'(1));
        check("timeout_state", 64'(dbg_state), 64'(ST_LOAD));
        check("timeout_no_valid", 64'(bus.result_valid_out), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("timeout_error_sticky", 64'(bus.error_out), 64'(1));
        core_mute = 0;
        load_pair(ID_A, ID_B, 0, 1);
        check("error_cleared", 64'(bus.error_out), 64'(0));
        wait_done();
`else
        check("error_tied_low", 64'(bus.error_out), 64'(0));
`endif

        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
